// File: rtl/calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_seq
// Purpose  : Keypad entry sequencer feeding a calculator ALU (operands, op,
//            issue pulse, result capture, chained expressions).
// Revision : 1.0
// ============================================================================
module calc_entry_seq #(
  parameter int MAX_DIGITS  = 9,
  parameter int ALU_LATENCY = 1
) (
  input  logic        _clock,
  input  logic        _reset,
  input  logic        _digit_valid,
  input  logic [3:0]  _digit,
  input  logic        _op_valid,
  input  logic [3:0]  _op_key,
  input  logic        _eq_valid,
  input  logic        _clr_valid,
  input  logic [31:0] _result,
  output logic [31:0] _op1,
  output logic [31:0] _op2,
  output logic [3:0]  _opcao,
  output logic        _issue,
  output logic        _busy,
  output logic        _done,
  output logic        _error,
  output logic [31:0] _display
);

  localparam int                  c_CNT_W     = $clog2(MAX_DIGITS + 1);
  localparam int                  c_WAIT_W    = $clog2(ALU_LATENCY + 2);
  localparam logic [c_CNT_W-1:0]  c_MAX_CNT   = c_CNT_W'(MAX_DIGITS);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(ALU_LATENCY);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [3:0]          c_OP_DIV    = 4'b0001;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t              r_state,   w_state_nx;
  logic [31:0]         r_op1,     w_op1_nx;
  logic [31:0]         r_op2,     w_op2_nx;
  logic [3:0]          r_opcao,   w_opcao_nx;
  logic [3:0]          r_pend_op, w_pend_nx;
  logic [3:0]          r_chain_op, w_chain_nx;
  logic [c_CNT_W-1:0]  r_count,   w_count_nx;
  logic [c_WAIT_W-1:0] r_wait,    w_wait_nx;
  logic                r_issue,   w_issue_nx;
  logic                r_busy,    w_busy_nx;
  logic                r_done,    w_done_nx;
  logic                r_error,   w_error_nx;
  logic [31:0]         r_display, w_display_nx;

  logic [31:0] w_acc;
  logic [35:0] w_acc_new;
  logic        w_digit_key;
  logic        w_digit_ok;
  logic        w_op_ok;
  logic        w_eval;

  // Accumulate at 36 bits so an overflowing digit can be rejected before the write.
  assign w_acc       = (r_state == S_ENTER_B) ? r_op2 : r_op1;
  assign w_acc_new   = ({4'b0000, w_acc} * 36'd10) + {32'd0, _digit};
  assign w_digit_key = _digit_valid && (_digit <= 4'd9);
  assign w_digit_ok  = w_digit_key && (r_count < c_MAX_CNT) && (w_acc_new[35:32] == 4'b0000);
  assign w_op_ok     = _op_valid && $onehot(_op_key);
  assign w_eval      = (r_state == S_ENTER_B) &&
                       (_eq_valid || (w_op_ok && (r_count != '0)));

  always_comb begin
    w_state_nx   = r_state;
    w_op1_nx     = r_op1;
    w_op2_nx     = r_op2;
    w_opcao_nx   = 4'b0000;
    w_pend_nx    = r_pend_op;
    w_chain_nx   = r_chain_op;
    w_count_nx   = r_count;
    w_wait_nx    = r_wait;
    w_issue_nx   = 1'b0;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_error_nx   = r_error;
    w_display_nx = r_display;

    if (_clr_valid) begin
      w_state_nx   = S_ENTER_A;
      w_op1_nx     = '0;
      w_op2_nx     = '0;
      w_pend_nx    = 4'b0000;
      w_chain_nx   = 4'b0000;
      w_count_nx   = '0;
      w_wait_nx    = '0;
      w_busy_nx    = 1'b0;
      w_error_nx   = 1'b0;
      w_display_nx = '0;
    end else begin
      case (r_state)
        S_ENTER_A, S_ENTER_B: begin
          if (w_eval) begin
            w_chain_nx = _eq_valid ? 4'b0000 : _op_key;
            if ((r_pend_op == c_OP_DIV) && (r_op2 == '0)) begin
              w_state_nx = S_ERR;
              w_error_nx = 1'b1;
            end else begin
              w_opcao_nx = r_pend_op;
              w_issue_nx = 1'b1;
              w_busy_nx  = 1'b1;
              w_state_nx = S_ISSUE;
            end
          end else if (_eq_valid) begin
            w_state_nx = r_state;
          end else if (w_op_ok) begin
            w_pend_nx = _op_key;
            if (r_state == S_ENTER_A) begin
              w_op2_nx   = '0;
              w_count_nx = '0;
              w_state_nx = S_ENTER_B;
            end
          end else if (w_digit_ok) begin
            if (r_state == S_ENTER_A) w_op1_nx = w_acc_new[31:0];
            else                      w_op2_nx = w_acc_new[31:0];
            w_display_nx = w_acc_new[31:0];
            w_count_nx   = r_count + c_CNT_ONE;
          end
        end
        S_ISSUE: begin
          w_wait_nx  = c_WAIT_INIT;
          w_state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (r_wait <= c_WAIT_ONE) begin
            w_display_nx = _result;
            w_op1_nx     = _result;
            w_done_nx    = 1'b1;
            w_busy_nx    = 1'b0;
            w_count_nx   = '0;
            w_wait_nx    = '0;
            if (r_chain_op != 4'b0000) begin
              w_pend_nx  = r_chain_op;
              w_chain_nx = 4'b0000;
              w_op2_nx   = '0;
              w_state_nx = S_ENTER_B;
            end else begin
              w_state_nx = S_DONE;
            end
          end else begin
            w_wait_nx = r_wait - c_WAIT_ONE;
          end
        end
        S_DONE: begin
          if (_eq_valid) begin
            w_state_nx = S_DONE;
          end else if (w_op_ok) begin
            w_pend_nx  = _op_key;
            w_op2_nx   = '0;
            w_count_nx = '0;
            w_state_nx = S_ENTER_B;
          end else if (w_digit_key) begin
            w_op1_nx     = {28'd0, _digit};
            w_display_nx = {28'd0, _digit};
            w_count_nx   = c_CNT_ONE;
            w_state_nx   = S_ENTER_A;
          end
        end
        default: begin
          w_state_nx = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_state    <= S_ENTER_A;
      r_op1      <= '0;
      r_op2      <= '0;
      r_opcao    <= 4'b0000;
      r_pend_op  <= 4'b0000;
      r_chain_op <= 4'b0000;
      r_count    <= '0;
      r_wait     <= '0;
      r_issue    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_display  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_op1      <= w_op1_nx;
      r_op2      <= w_op2_nx;
      r_opcao    <= w_opcao_nx;
      r_pend_op  <= w_pend_nx;
      r_chain_op <= w_chain_nx;
      r_count    <= w_count_nx;
      r_wait     <= w_wait_nx;
      r_issue    <= w_issue_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_error    <= w_error_nx;
      r_display  <= w_display_nx;
    end
  end

  assign _op1     = r_op1;
  assign _op2     = r_op2;
  assign _opcao   = r_opcao;
  assign _issue   = r_issue;
  assign _busy    = r_busy;
  assign _done    = r_done;
  assign _error   = r_error;
  assign _display = r_display;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_entry_seq
// Purpose  : Self-checking bench for calc_entry_seq (vectors, corner cases,
//            random keystrokes against a keystroke-level reference model).
// Revision : 1.0
// ============================================================================
module tb_calc_entry_seq;

  localparam int K_DIG = 0, K_OP = 1, K_EQ = 2, K_CLR = 3;
  localparam int O_DIV = 1, O_MUL = 2, O_SUB = 4, O_ADD = 8;
  localparam int MD_A = 0, MD_B = 1, MD_DONE = 2, MD_ERR = 3;
  localparam int MAXD = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0, op_valid = 1'b0, eq_valid = 1'b0, clr_valid = 1'b0;
  logic [3:0]  digit = 4'd0, op_key = 4'd0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] op1, op2, display;
  logic [3:0]  opcao;
  logic        issue, busy, done, error;
  logic [31:0] t_op1, t_op2, t_display;
  logic [3:0]  t_opcao;
  logic        t_issue, t_busy, t_done, t_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_entry_seq #(.MAX_DIGITS(9), .ALU_LATENCY(1)) dut (
    ._clock(clk), ._reset(rst), ._digit_valid(digit_valid), ._digit(digit),
    ._op_valid(op_valid), ._op_key(op_key), ._eq_valid(eq_valid), ._clr_valid(clr_valid),
    ._result(alu_res), ._op1(op1), ._op2(op2), ._opcao(opcao), ._issue(issue),
    ._busy(busy), ._done(done), ._error(error), ._display(display));

  calc_entry_seq #(.MAX_DIGITS(10), .ALU_LATENCY(1)) dut10 (
    ._clock(clk), ._reset(rst), ._digit_valid(digit_valid), ._digit(digit),
    ._op_valid(op_valid), ._op_key(op_key), ._eq_valid(eq_valid), ._clr_valid(clr_valid),
    ._result(alu_res), ._op1(t_op1), ._op2(t_op2), ._opcao(t_opcao), ._issue(t_issue),
    ._busy(t_busy), ._done(t_done), ._error(t_error), ._display(t_display));

  function automatic longint alu_fn(input longint a, input longint b, input int op);
    longint r;
    case (op)
      O_DIV:   r = (b == 0) ? 64'd0 : a / b;
      O_MUL:   r = a * b;
      O_SUB:   r = a - b;
      O_ADD:   r = a + b;
      default: r = 0;
    endcase
    return r & 64'hFFFF_FFFF;
  endfunction

  // ALU samples operands on the edge that ends the issue cycle; result valid one cycle later.
  always @(posedge clk)
    if (issue) alu_res <= 32'(alu_fn(longint'(op1), longint'(op2), int'(opcao)));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int kind, input int val);
    @(negedge clk);
    digit_valid = (kind == K_DIG);
    op_valid    = (kind == K_OP);
    eq_valid    = (kind == K_EQ);
    clr_valid   = (kind == K_CLR);
    digit       = 4'(val);
    op_key      = 4'(val);
    @(negedge clk);
    digit_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0; clr_valid = 1'b0;
  endtask

  task automatic step(input string tag, input int kind, input int val, input bit e_iss,
                      input int e_opc, input longint e_a, input longint e_b,
                      input longint e_disp, input longint e_op1, input longint e_op2,
                      input bit e_err);
    int n_iss, iss_at, n_done, done_at, n_bad;
    logic [3:0] s_opc;
    logic [31:0] s_a, s_b;
    logic s_busy;
    press(kind, val);
    n_iss = 0; iss_at = -1; n_done = 0; done_at = -1; n_bad = 0;
    s_opc = 4'd0; s_a = 32'd0; s_b = 32'd0; s_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if ((opcao != 4'b0000) != issue) n_bad++;
      if (issue) begin
        n_iss++;
        if (iss_at < 0) begin
          iss_at = i; s_opc = opcao; s_a = op1; s_b = op2; s_busy = busy;
        end
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
    end
    chk({tag, ".issue_cnt"}, n_iss, e_iss ? 1 : 0);
    chk({tag, ".opcao_vs_issue"}, n_bad, 0);
    if (e_iss) begin
      chk({tag, ".issue_at"}, iss_at, 0);
      chk({tag, ".opcao"}, longint'(s_opc), e_opc);
      chk({tag, ".issue_op1"}, longint'(s_a), e_a);
      chk({tag, ".issue_op2"}, longint'(s_b), e_b);
      chk({tag, ".busy_at_issue"}, longint'(s_busy), 1);
      chk({tag, ".done_cnt"}, n_done, 1);
      chk({tag, ".done_at"}, done_at, 2);
    end else begin
      chk({tag, ".done_cnt"}, n_done, 0);
    end
    chk({tag, ".display"}, longint'(display), e_disp);
    chk({tag, ".op1"}, longint'(op1), e_op1);
    chk({tag, ".op2"}, longint'(op2), e_op2);
    chk({tag, ".error"}, longint'(error), longint'(e_err));
    chk({tag, ".busy_idle"}, longint'(busy), 0);
  endtask

  // Keystroke-level reference model
  int     m_mode = MD_A;
  longint m_a = 0, m_b = 0, m_disp = 0;
  int     m_cnt = 0, m_pend = 0;
  bit     m_err = 1'b0;

  task automatic model_apply(input int kind, input int val, output bit e_iss,
                             output int e_opc, output longint e_a, output longint e_b);
    bit dig_ok, op_ok;
    longint nv;
    dig_ok = (kind == K_DIG) && (val < 10);
    op_ok  = (kind == K_OP) && (val == 1 || val == 2 || val == 4 || val == 8);
    e_iss = 1'b0; e_opc = 0; e_a = 0; e_b = 0;
    if (kind == K_CLR) begin
      m_mode = MD_A; m_a = 0; m_b = 0; m_cnt = 0; m_pend = 0; m_disp = 0; m_err = 1'b0;
    end else if (m_mode == MD_A || m_mode == MD_B) begin
      if (m_mode == MD_B && (kind == K_EQ || (op_ok && m_cnt > 0))) begin
        if (m_pend == O_DIV && m_b == 0) begin
          m_mode = MD_ERR; m_err = 1'b1;
        end else begin
          e_iss = 1'b1; e_opc = m_pend; e_a = m_a; e_b = m_b;
          m_a = alu_fn(m_a, m_b, m_pend); m_disp = m_a; m_cnt = 0;
          if (kind == K_OP) begin m_pend = val; m_b = 0; m_mode = MD_B; end
          else m_mode = MD_DONE;
        end
      end else if (op_ok) begin
        m_pend = val;
        if (m_mode == MD_A) begin m_b = 0; m_cnt = 0; m_mode = MD_B; end
      end else if (dig_ok && m_cnt < MAXD) begin
        nv = ((m_mode == MD_A) ? m_a : m_b) * 10 + val;
        if (nv <= 64'hFFFF_FFFF) begin
          if (m_mode == MD_A) m_a = nv; else m_b = nv;
          m_disp = nv; m_cnt++;
        end
      end
    end else if (m_mode == MD_DONE) begin
      if (op_ok) begin
        m_pend = val; m_b = 0; m_cnt = 0; m_mode = MD_B;
      end else if (dig_ok) begin
        m_a = val; m_disp = val; m_cnt = 1; m_mode = MD_A;
      end
    end
  endtask

  typedef struct {
    int kind; int val; bit iss; int opc;
    longint a; longint b; longint disp; longint op1; longint op2; bit err;
  } vec_t;
  vec_t tbl[$];

  task automatic tv(input int kind, input int val, input bit iss, input int opc,
                    input longint a, input longint b, input longint disp,
                    input longint o1, input longint o2, input bit err);
    vec_t v;
    v.kind = kind; v.val = val; v.iss = iss; v.opc = opc; v.a = a; v.b = b;
    v.disp = disp; v.op1 = o1; v.op2 = o2; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".op1"}, longint'(op1), 0);
    chk({tag, ".op2"}, longint'(op2), 0);
    chk({tag, ".opcao"}, longint'(opcao), 0);
    chk({tag, ".issue"}, longint'(issue), 0);
    chk({tag, ".busy"}, longint'(busy), 0);
    chk({tag, ".done"}, longint'(done), 0);
    chk({tag, ".error"}, longint'(error), 0);
    chk({tag, ".display"}, longint'(display), 0);
  endtask

  task automatic start_wait_op();
    // 1 + 2 = then return at the negedge where the DUT sits in WAIT
    press(K_CLR, 0); press(K_DIG, 1); press(K_OP, O_ADD); press(K_DIG, 2);
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
    chk("mid.issue", longint'(issue), 1);
    @(negedge clk);
    chk("mid.busy", longint'(busy), 1);
  endtask

  initial begin
    bit e_iss;
    int e_opc, kind, val, r, n_done;
    longint e_a, e_b;

    // Stimulus table: kind, val, issue?, opcao, issue op1/op2, display, op1, op2, error
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tv(K_DIG, 2, 0, 0, 0, 0, 12, 12, 0, 0);
    tv(K_OP, O_ADD, 0, 0, 0, 0, 12, 12, 0, 0);
    tv(K_DIG, 3, 0, 0, 0, 0, 3, 12, 3, 0);
    tv(K_DIG, 4, 0, 0, 0, 0, 34, 12, 34, 0);
    tv(K_EQ, 0, 1, O_ADD, 12, 34, 46, 46, 34, 0);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tv(K_DIG, 2, 0, 0, 0, 0, 12, 12, 0, 0);
    tv(K_OP, O_MUL, 0, 0, 0, 0, 12, 12, 0, 0);
    tv(K_DIG, 3, 0, 0, 0, 0, 3, 12, 3, 0);
    tv(K_OP, O_SUB, 1, O_MUL, 12, 3, 36, 36, 0, 0);
    tv(K_DIG, 6, 0, 0, 0, 0, 6, 36, 6, 0);
    tv(K_EQ, 0, 1, O_SUB, 36, 6, 30, 30, 6, 0);
    tv(K_OP, O_ADD, 0, 0, 0, 0, 30, 30, 0, 0);
    tv(K_DIG, 4, 0, 0, 0, 0, 4, 30, 4, 0);
    tv(K_EQ, 0, 1, O_ADD, 30, 4, 34, 34, 4, 0);
    tv(K_DIG, 9, 0, 0, 0, 0, 9, 9, 4, 0);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 8, 0, 0, 0, 0, 8, 8, 0, 0);
    tv(K_OP, O_DIV, 0, 0, 0, 0, 8, 8, 0, 0);
    tv(K_DIG, 0, 0, 0, 0, 0, 0, 8, 0, 0);
    tv(K_EQ, 0, 0, 0, 0, 0, 0, 8, 0, 1);
    tv(K_DIG, 5, 0, 0, 0, 0, 0, 8, 0, 1);
    tv(K_OP, O_ADD, 0, 0, 0, 0, 0, 8, 0, 1);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 7, 0, 0, 0, 0, 7, 7, 0, 0);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 5, 0, 0, 0, 0, 5, 5, 0, 0);
    tv(K_OP, O_ADD, 0, 0, 0, 0, 5, 5, 0, 0);
    tv(K_OP, O_SUB, 0, 0, 0, 0, 5, 5, 0, 0);
    tv(K_DIG, 2, 0, 0, 0, 0, 2, 5, 2, 0);
    tv(K_EQ, 0, 1, O_SUB, 5, 2, 3, 3, 2, 0);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_EQ, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_OP, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 3, 0, 0, 0, 0, 3, 3, 0, 0);
    tv(K_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(K_DIG, 9, 0, 0, 0, 0, 9, 9, 0, 0);
    tv(K_OP, O_DIV, 0, 0, 0, 0, 9, 9, 0, 0);
    tv(K_DIG, 3, 0, 0, 0, 0, 3, 9, 3, 0);
    tv(K_EQ, 0, 1, O_DIV, 9, 3, 3, 3, 3, 0);

    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].kind, tbl[i].val, tbl[i].iss, tbl[i].opc,
           tbl[i].a, tbl[i].b, tbl[i].disp, tbl[i].op1, tbl[i].op2, tbl[i].err);

    // Digit limit (9-digit DUT) and 32-bit overflow rejection (10-digit DUT)
    press(K_CLR, 0);
    press(K_DIG, 4); press(K_DIG, 2); press(K_DIG, 9); press(K_DIG, 4); press(K_DIG, 9);
    press(K_DIG, 6); press(K_DIG, 7); press(K_DIG, 2); press(K_DIG, 9);
    press(K_DIG, 6);
    chk("maxdig.disp9", longint'(display), 429496729);
    chk("ovf.disp10", longint'(t_display), 429496729);
    press(K_DIG, 5);
    chk("maxdig.disp9_b", longint'(display), 429496729);
    chk("ovf.disp10_max", longint'(t_display), 64'd4294967295);
    press(K_DIG, 7);
    chk("ovf.disp10_limit", longint'(t_display), 64'd4294967295);

    // Asynchronous reset while waiting on the ALU
    start_wait_op();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    repeat (4) begin @(negedge clk); if (done) n_done++; end
    chk("async_rst.no_done", n_done, 0);
    chk("async_rst.display", longint'(display), 0);

    // Clear while waiting: late result must be discarded
    start_wait_op();
    clr_valid = 1'b1;
    @(negedge clk); clr_valid = 1'b0;
    check_all_zero("clr_wait");
    n_done = 0;
    repeat (4) begin @(negedge clk); if (done) n_done++; end
    chk("clr_wait.no_done", n_done, 0);
    chk("clr_wait.display", longint'(display), 0);

    // Random keystrokes against the reference model
    model_apply(K_CLR, 0, e_iss, e_opc, e_a, e_b);
    step("rnd_init", K_CLR, 0, e_iss, e_opc, e_a, e_b, m_disp, m_a, m_b, m_err);
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) begin
        kind = K_DIG; val = (r < 12) ? 0 : int'($urandom_range(0, 9));
      end else if (r < 54) begin
        kind = K_DIG; val = int'($urandom_range(10, 15));
      end else if (r < 74) begin
        kind = K_OP;
        case ($urandom_range(0, 3))
          0: val = O_DIV;
          1: val = O_MUL;
          2: val = O_SUB;
          default: val = O_ADD;
        endcase
      end else if (r < 77) begin
        kind = K_OP;
        case ($urandom_range(0, 2))
          0: val = 0;
          1: val = 3;
          default: val = 15;
        endcase
      end else if (r < 95) begin
        kind = K_EQ; val = 0;
      end else begin
        kind = K_CLR; val = 0;
      end
      model_apply(kind, val, e_iss, e_opc, e_a, e_b);
      step($sformatf("rnd%0d", n), kind, val, e_iss, e_opc, e_a, e_b,
           m_disp, m_a, m_b, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_entry_seq.md
Name: calc_entry_seq

Overview:
- Keypad-facing sequencer that sits directly upstream of the calculator ALU.
- Accumulates decimal digit keystrokes into two 32-bit unsigned operands and latches the selected operator.
- Drives the ALU operand and operator inputs for exactly one issue cycle, waits the ALU latency, then captures the ALU result for display.
- Supports chained expressions: the captured result becomes the next first operand.

Parameters:
- MAX_DIGITS, 9: max decimal digits accepted per operand; further digits are ignored.
- ALU_LATENCY, 1: cycles from the ALU sampling its inputs to its result being stable.

Ports:
- _clock  input  1  system clock; all state changes on posedge.
- _reset  input  1  asynchronous, active-high reset.
- _digit_valid  input  1  digit key event this cycle.
- _digit  input  4  digit value 0-9; values 10-15 are ignored.
- _op_valid  input  1  operator key event.
- _op_key  input  4  one-hot operator: 0001 div, 0010 mul, 0100 sub, 1000 add; any other code is ignored.
- _eq_valid  input  1  equals key event.
- _clr_valid  input  1  clear key event.
- _result  input  32  ALU result.
- _op1  output  32  ALU operand 1 (registered).
- _op2  output  32  ALU operand 2 (registered).
- _opcao  output  4  ALU operator (registered); 0000 except in the issue cycle.
- _issue  output  1  one-cycle pulse, coincident with non-zero _opcao.
- _busy  output  1  high in ISSUE/WAIT.
- _done  output  1  one-cycle pulse when a result is captured.
- _error  output  1  sticky divide-by-zero flag.
- _display  output  32  current entry value or last result.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = ENTER_A.
  - _op1 = _op2 = _display = 0, _opcao = 0000, pending op = 0000, digit count = 0.
  - _issue = _busy = _done = _error = 0.
- Event priority, one event accepted per cycle: clear > eq > op > digit.
- States: ENTER_A, ENTER_B, ISSUE, WAIT, DONE, ERR.
- Digit entry (ENTER_A into _op1, ENTER_B into _op2):
  - acc <= acc*10 + digit; _display <= new acc; count++.
  - Digit ignored if count == MAX_DIGITS.
  - Digit ignored if the result would exceed 2^32-1. Arithmetic is done at 36 bits and compared before the write.
- Op in ENTER_A:
  - Latch pending op, clear _op2 and count, go to ENTER_B.
  - _op1 keeps its value; 0 if no digits were entered.
- Op in ENTER_B:
  - If count == 0: replace pending op, stay in ENTER_B.
  - Otherwise: evaluate exactly as eq, and remember the new op as chained op.
- Eq in ENTER_B with pending op:
  - If op == 0001 and _op2 == 0: go to ERR, set _error = 1, no issue.
  - Otherwise, at edge E: _opcao <= pending op, _issue <= 1, _busy <= 1, go to ISSUE.
- Eq in ENTER_A or DONE: no effect.
- ISSUE (one cycle): at edge E+1, _opcao <= 0000, _issue <= 0, wait counter <= ALU_LATENCY, go to WAIT. The ALU samples at edge E+1.
- WAIT: counter decrements each cycle. When it reaches 0 (edge E+1+ALU_LATENCY):
  - _display <= _result, _op1 <= _result, _done <= 1 for one cycle, _busy <= 0.
  - If a chained op is present: pending op <= chained op, _op2 <= 0, count <= 0, go to ENTER_B.
  - Otherwise: go to DONE.
- DONE:
  - Op: pending op <= op, _op2 <= 0, go to ENTER_B (result chaining).
  - Digit: start a new expression; _op1 <= digit, count = 1, go to ENTER_A.
- ERR: ignores everything except clear.
- Clear (any state, including ISSUE/WAIT):
  - Same values as reset, applied synchronously.
  - A result arriving after a clear is discarded.
- Digit, op and eq events in ISSUE/WAIT are dropped, not queued.
- All arithmetic is unsigned 32-bit. Operand widths never wrap; overflowing digits are rejected instead.

Test Plan:
- Reset, keys 1,2,+,3,4,= -> _opcao = 1000 and _issue = 1 for exactly one cycle, _op1 = 12, _op2 = 34; with the ALU model returning 46, _done pulses 2 cycles after the eq edge and _display = 46.
- Keys 1,2,*,3,- then 6,= -> first issue 12*3 (0010); after capture _op1 = 36 and pending op 0100; second issue gives _display = 30.
- Keys 8,/,0,= -> no _issue, _error = 1, _display unchanged at 0; then digit 5 is ignored; clear -> _error = 0, state ENTER_A.
- Keys 4,2,9,4,9,6,7,2,9,5 -> _display = 429496729 (10th digit dropped by MAX_DIGITS); with MAX_DIGITS = 10, entering 4294967296 leaves _display = 429496729 (overflow reject).
- Keys 5,+,-,2,= -> issue with _opcao = 0100, _op1 = 5, _op2 = 2 (operator replaced).
- Assert _reset asynchronously mid-WAIT -> all outputs 0 immediately, no _done pulse; repeat with clear instead -> same result at the next edge, and the late ALU result is not captured.
